// File: rtl/vmem_port_pkg.sv
// Shared constants and types for the CPU-side video-memory access port.
// Port offsets are relative to the 8-aligned base of the port window.
package vmem_port_pkg;

  localparam logic [2:0] OFS_PTR_LO  = 3'd0;
  localparam logic [2:0] OFS_PTR_HI  = 3'd1;
  localparam logic [2:0] OFS_DATA    = 3'd2;
  localparam logic [2:0] OFS_STRIDE  = 3'd3;
  localparam logic [2:0] OFS_CNT_LO  = 3'd4;
  localparam logic [2:0] OFS_CNT_HI  = 3'd5;
  localparam logic [2:0] OFS_CMD     = 3'd6;
  localparam logic [2:0] OFS_FILLVAL = 3'd7;

  localparam int unsigned CMD_START    = 0;
  localparam int unsigned CMD_ABORT    = 1;
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_OVERRUN = 1;

  typedef enum logic {
    StIdle,
    StFill
  } state_e;

endpackage

// File: rtl/vmem_cpu_port_if.sv
// CPU port bus plus video-RAM write/read ports of the access port.
// The slave modport is the port block; master is its environment.
interface vmem_cpu_port_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic [7:0]        port_id;
  logic              write_strobe;
  logic              read_strobe;
  logic [7:0]        out_port;
  logic [7:0]        in_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              busy;
  logic              done;

  modport slave (
    input  port_id, write_strobe, read_strobe, out_port, mem_rd_data,
    output in_data, mem_we, mem_wr_addr, mem_wdata, mem_rd_addr, busy, done
  );

  modport master (
    output port_id, write_strobe, read_strobe, out_port, mem_rd_data,
    input  in_data, mem_we, mem_wr_addr, mem_wdata, mem_rd_addr, busy, done
  );
endinterface

// File: rtl/vmem_cpu_port.sv
// CPU-side video-memory port: strided pointer, data read/write with advance,
// and a fill engine that streams one write per cycle from a loaded count.
module vmem_cpu_port
  import vmem_port_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter logic [7:0]  BASE_PORT = 8'h20
) (
  input logic            clk,
  input logic            rst,
  vmem_cpu_port_if.slave bus
);

  state_e            st_q, st_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_step;
  logic [7:0]        stride_q, stride_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] fillval_q, fillval_d;
  logic              ovr_q, ovr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic       in_win, wr_hit, rd_hit, abort, fill_step;
  logic [2:0] ofs;
  logic [7:0] in_data_c;

  assign ofs      = bus.port_id[2:0];
  assign in_win   = (bus.port_id[7:3] == BASE_PORT[7:3]);
  assign wr_hit   = bus.write_strobe & in_win;
  assign rd_hit   = bus.read_strobe & in_win;
  assign abort    = wr_hit && (ofs == OFS_CMD) && bus.out_port[CMD_ABORT];
  assign ptr_step = ptr_q + ADDR_W'(stride_q);

  always_comb begin
    st_d      = st_q;
    ptr_d     = ptr_q;
    stride_d  = stride_q;
    cnt_d     = cnt_q;
    fillval_d = fillval_q;
    ovr_d     = ovr_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    fill_step = 1'b0;

    if (wr_hit) begin
      if (busy_q) begin
        // Only CMD is live during a fill; abort is handled below.
        if (ofs != OFS_CMD) ovr_d = 1'b1;
      end else begin
        unique case (ofs)
          OFS_PTR_LO:  ptr_d[7:0] = bus.out_port;
          OFS_PTR_HI:  ptr_d[ADDR_W-1:8] = bus.out_port[ADDR_W-9:0];
          OFS_DATA: begin
            we_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = bus.out_port[DATA_W-1:0];
            ptr_d   = ptr_step;
          end
          OFS_STRIDE:  stride_d = bus.out_port;
          OFS_CNT_LO:  cnt_d[7:0] = bus.out_port;
          OFS_CNT_HI:  cnt_d[15:8] = bus.out_port;
          OFS_CMD: begin
            if (bus.out_port[CMD_START] && !bus.out_port[CMD_ABORT]) begin
              if (cnt_q == 16'd0) done_d = 1'b1;
              else                fill_step = 1'b1;
            end
          end
          OFS_FILLVAL: fillval_d = bus.out_port[DATA_W-1:0];
        endcase
      end
    end

    if (rd_hit && !busy_q && (ofs == OFS_DATA)) ptr_d = ptr_step;
    if (rd_hit && (ofs == OFS_CMD)) ovr_d = 1'b0;

    if (st_q == StFill) begin
      if (abort) st_d = StIdle;
      else       fill_step = 1'b1;
    end

    // The start strobe itself issues the first fill write.
    if (fill_step) begin
      we_d    = 1'b1;
      waddr_d = ptr_q;
      wdata_d = fillval_q;
      ptr_d   = ptr_step;
      cnt_d   = cnt_q - 16'd1;
      busy_d  = 1'b1;
      if (cnt_q == 16'd1) begin
        st_d   = StIdle;
        done_d = 1'b1;
      end else begin
        st_d = StFill;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= StIdle;
      ptr_q     <= '0;
      stride_q  <= 8'd1;
      cnt_q     <= '0;
      fillval_q <= '0;
      ovr_q     <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      ptr_q     <= ptr_d;
      stride_q  <= stride_d;
      cnt_q     <= cnt_d;
      fillval_q <= fillval_d;
      ovr_q     <= ovr_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    in_data_c = '0;
    if (in_win) begin
      unique case (ofs)
        OFS_DATA: in_data_c[DATA_W-1:0] = bus.mem_rd_data;
        OFS_CMD: begin
          in_data_c[STAT_BUSY]    = busy_q;
          in_data_c[STAT_OVERRUN] = ovr_q;
        end
        default: in_data_c = '0;
      endcase
    end
  end

  assign bus.in_data     = in_data_c;
  assign bus.mem_we      = we_q;
  assign bus.mem_wr_addr = waddr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_rd_addr = ptr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_vmem_cpu_port.sv
// Bench for vmem_cpu_port: a cycle-indexed schedule of expected mem writes,
// busy and done built from the register-level rules, checked every cycle.
module tb_vmem_cpu_port;
  import vmem_port_pkg::*;

  localparam int         NC   = 16384;
  localparam logic [7:0] BASE = 8'h20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vmem_cpu_port_if #(.ADDR_W(16), .DATA_W(8)) bus ();
  vmem_cpu_port #(.ADDR_W(16), .DATA_W(8), .BASE_PORT(BASE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Video RAM with synchronous read, written only by the DUT.
  bit [7:0] vram [65536];
  always @(posedge clk) begin
    if (bus.mem_we) vram[bus.mem_wr_addr] <= bus.mem_wdata;
    bus.mem_rd_data <= vram[bus.mem_rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model state.
  bit          exp_we   [NC];
  logic [15:0] exp_addr [NC];
  logic [7:0]  exp_data [NC];
  bit          exp_busy [NC];
  bit          exp_done [NC];
  bit   [7:0]  mm [65536];
  logic [15:0] m_ptr = 16'h0;
  logic [7:0]  m_stride = 8'd1;
  logic [15:0] m_cnt = 16'h0;
  logic [7:0]  m_fill = 8'h0;
  bit          m_ovr = 1'b0;
  int          fs = 0;
  int          fn = 0;
  logic [15:0] f_ptr0 = 16'h0;
  logic [7:0]  f_stride = 8'd1;

  // Observations.
  logic [15:0] wlog [$];
  int          dn_cnt = 0;
  int          busy_cyc = 0;
  logic [15:0] last_done_addr = 16'h0;

  function automatic bit m_busy(input int c);
    return (fn != 0) && (c >= fs + 1) && (c <= fs + fn);
  endfunction

  always @(negedge clk) begin
    if (!rst && cyc > 0 && cyc < NC) begin
      chk("mem_we", 32'(bus.mem_we), 32'(exp_we[cyc]));
      if (exp_we[cyc]) begin
        chk("mem_wr_addr", 32'(bus.mem_wr_addr), 32'(exp_addr[cyc]));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(exp_data[cyc]));
        mm[exp_addr[cyc]] = exp_data[cyc];
      end
      chk("busy", 32'(bus.busy), 32'(exp_busy[cyc]));
      chk("done", 32'(bus.done), 32'(exp_done[cyc]));
      if (bus.mem_we) wlog.push_back(bus.mem_wr_addr);
      if (bus.done) begin
        dn_cnt++;
        last_done_addr = bus.mem_wr_addr;
      end
      if (bus.busy) busy_cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [2:0] ofs, input logic [7:0] val);
    int k;
    int d;
    tick();
    bus.port_id = BASE | {5'd0, ofs};
    bus.out_port = val;
    bus.write_strobe = 1'b1;
    k = cyc;
    if (m_busy(k)) begin
      if (ofs == OFS_CMD) begin
        if (val[1]) begin
          d = k - fs;
          for (int c = k + 1; c <= fs + fn; c++) begin
            exp_we[c] = 1'b0;
            exp_busy[c] = 1'b0;
            exp_done[c] = 1'b0;
          end
          m_ptr = f_ptr0 + 16'(d * int'(f_stride));
          m_cnt = 16'(fn - d);
          fn = d;
        end
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      case (ofs)
        OFS_PTR_LO:  m_ptr[7:0] = val;
        OFS_PTR_HI:  m_ptr[15:8] = val;
        OFS_DATA: begin
          exp_we[k+1] = 1'b1;
          exp_addr[k+1] = m_ptr;
          exp_data[k+1] = val;
          m_ptr = m_ptr + 16'(m_stride);
        end
        OFS_STRIDE:  m_stride = val;
        OFS_CNT_LO:  m_cnt[7:0] = val;
        OFS_CNT_HI:  m_cnt[15:8] = val;
        OFS_CMD: begin
          if (val[0] && !val[1]) begin
            if (m_cnt == 16'd0) begin
              exp_done[k+1] = 1'b1;
            end else begin
              fs = k;
              fn = int'(m_cnt);
              f_ptr0 = m_ptr;
              f_stride = m_stride;
              for (int i = 0; i < fn; i++) begin
                exp_we[k+1+i] = 1'b1;
                exp_addr[k+1+i] = m_ptr + 16'(i * int'(m_stride));
                exp_data[k+1+i] = m_fill;
                exp_busy[k+1+i] = 1'b1;
              end
              exp_done[k+fn] = 1'b1;
              m_ptr = m_ptr + 16'(fn * int'(m_stride));
              m_cnt = 16'd0;
            end
          end
        end
        default:     m_fill = val;
      endcase
    end
    tick();
    bus.write_strobe = 1'b0;
  endtask

  task automatic cpu_rd(input logic [2:0] ofs, input bit win, output logic [7:0] got);
    int k;
    logic [7:0] e;
    logic [15:0] p;
    bit do_chk;
    repeat (3) tick();
    bus.port_id = (win ? BASE : 8'h48) | {5'd0, ofs};
    bus.read_strobe = 1'b1;
    k = cyc;
    p = m_ptr;
    do_chk = 1'b1;
    e = 8'h00;
    if (win && ofs == OFS_CMD) begin
      e = {6'd0, m_ovr, m_busy(k)};
      m_ovr = 1'b0;
    end else if (win && ofs == OFS_DATA) begin
      if (m_busy(k) || (fn != 0 && k < fs + fn + 2)) do_chk = 1'b0;
      else e = mm[m_ptr];
      if (!m_busy(k)) m_ptr = m_ptr + 16'(m_stride);
    end
    @(negedge clk);
    got = bus.in_data;
    if (do_chk) begin
      chk("in_data", 32'(got), 32'(e));
      if (win && ofs == OFS_DATA) chk("rd_addr_at_read", 32'(bus.mem_rd_addr), 32'(p));
    end
    tick();
    bus.read_strobe = 1'b0;
  endtask

  task automatic wait_idle();
    while (fn != 0 && cyc <= fs + fn + 2) tick();
    repeat (2) tick();
  endtask

  logic [7:0] g;
  int dn0, bc0, r;

  initial begin
    bus.port_id = 8'h00;
    bus.write_strobe = 1'b0;
    bus.read_strobe = 1'b0;
    bus.out_port = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_rd_addr", 32'(bus.mem_rd_addr), 32'h0);
    chk("rst_wr_addr", 32'(bus.mem_wr_addr), 32'h0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    cpu_rd(OFS_CMD, 1'b1, g);
    chk("rst_status", 32'(g), 32'h0);

    // Stride 1, two DATA writes.
    wlog.delete();
    cpu_wr(OFS_PTR_LO, 8'h00);
    cpu_wr(OFS_PTR_HI, 8'h01);
    cpu_wr(OFS_DATA, 8'hAA);
    cpu_wr(OFS_DATA, 8'hBB);
    repeat (2) tick();
    chk("seq_nwr", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("seq_addr0", 32'(wlog[0]), 32'h0100);
      chk("seq_addr1", 32'(wlog[1]), 32'h0101);
    end
    chk("seq_ptr", 32'(bus.mem_rd_addr), 32'h0102);
    chk("model_ptr", 32'(m_ptr), 32'h0102);
    cpu_wr(OFS_PTR_LO, 8'h00);
    cpu_rd(OFS_DATA, 1'b1, g);
    chk("readback_aa", 32'(g), 32'hAA);
    repeat (2) tick();
    chk("read_advance", 32'(bus.mem_rd_addr), 32'h0101);

    // Stride 3 with wrap.
    wlog.delete();
    cpu_wr(OFS_STRIDE, 8'd3);
    cpu_wr(OFS_PTR_LO, 8'hFE);
    cpu_wr(OFS_PTR_HI, 8'hFF);
    cpu_wr(OFS_DATA, 8'h11);
    cpu_wr(OFS_DATA, 8'h22);
    repeat (2) tick();
    chk("wrap_nwr", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("wrap_addr0", 32'(wlog[0]), 32'hFFFE);
      chk("wrap_addr1", 32'(wlog[1]), 32'h0001);
    end

    // Four-word fill, stride 2.
    cpu_wr(OFS_FILLVAL, 8'h05);
    cpu_wr(OFS_CNT_LO, 8'd4);
    cpu_wr(OFS_CNT_HI, 8'd0);
    cpu_wr(OFS_STRIDE, 8'd2);
    cpu_wr(OFS_PTR_LO, 8'h10);
    cpu_wr(OFS_PTR_HI, 8'h00);
    wlog.delete();
    dn0 = dn_cnt;
    bc0 = busy_cyc;
    cpu_wr(OFS_CMD, 8'h01);
    wait_idle();
    chk("fill_nwr", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      chk("fill_a0", 32'(wlog[0]), 32'h10);
      chk("fill_a3", 32'(wlog[3]), 32'h16);
    end
    chk("fill_busy_cycles", 32'(busy_cyc - bc0), 32'd4);
    chk("fill_done_count", 32'(dn_cnt - dn0), 32'd1);
    chk("fill_done_addr", 32'(last_done_addr), 32'h16);
    chk("fill_ptr", 32'(bus.mem_rd_addr), 32'h18);

    // Long fill aborted after ten writes, then resumed.
    cpu_wr(OFS_STRIDE, 8'd1);
    cpu_wr(OFS_PTR_LO, 8'h00);
    cpu_wr(OFS_PTR_HI, 8'h02);
    cpu_wr(OFS_CNT_LO, 8'hE8);
    cpu_wr(OFS_CNT_HI, 8'h03);
    wlog.delete();
    dn0 = dn_cnt;
    bc0 = busy_cyc;
    cpu_wr(OFS_CMD, 8'h01);
    while (cyc < fs + 9) tick();
    cpu_wr(OFS_CMD, 8'h02);
    wait_idle();
    chk("abort_nwr", 32'(wlog.size()), 32'd10);
    chk("abort_busy_cycles", 32'(busy_cyc - bc0), 32'd10);
    chk("abort_no_done", 32'(dn_cnt - dn0), 32'd0);
    chk("abort_ptr", 32'(bus.mem_rd_addr), 32'h020A);
    chk("model_cnt", 32'(m_cnt), 32'd990);
    cpu_wr(OFS_CMD, 8'h01);
    wait_idle();
    chk("resume_nwr", 32'(wlog.size()), 32'd1000);
    chk("resume_done", 32'(dn_cnt - dn0), 32'd1);
    chk("resume_ptr", 32'(bus.mem_rd_addr), 32'h05E8);

    // Register writes during a fill are dropped and flag overrun.
    cpu_wr(OFS_STRIDE, 8'd2);
    cpu_wr(OFS_CNT_LO, 8'd40);
    cpu_wr(OFS_CNT_HI, 8'd0);
    cpu_wr(OFS_CMD, 8'h01);
    cpu_wr(OFS_STRIDE, 8'd7);
    cpu_wr(OFS_DATA, 8'h99);
    cpu_rd(OFS_CMD, 1'b1, g);
    chk("ovr_status", 32'(g), 32'h03);
    cpu_rd(OFS_CMD, 1'b1, g);
    chk("ovr_cleared", 32'(g[1]), 32'h0);
    wait_idle();

    // Zero-count start.
    wlog.delete();
    dn0 = dn_cnt;
    bc0 = busy_cyc;
    cpu_wr(OFS_CMD, 8'h01);
    repeat (3) tick();
    chk("zero_nwr", 32'(wlog.size()), 32'd0);
    chk("zero_done", 32'(dn_cnt - dn0), 32'd1);
    chk("zero_busy", 32'(busy_cyc - bc0), 32'd0);

    // Asynchronous reset in the middle of a fill.
    cpu_wr(OFS_PTR_HI, 8'h03);
    cpu_wr(OFS_CNT_LO, 8'd50);
    cpu_wr(OFS_CMD, 8'h01);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_ptr", 32'(bus.mem_rd_addr), 32'h0);
    for (int c = cyc; c < NC && c <= fs + fn + 1; c++) begin
      exp_we[c] = 1'b0;
      exp_busy[c] = 1'b0;
      exp_done[c] = 1'b0;
    end
    fn = 0;
    m_ptr = 16'h0;
    m_stride = 8'd1;
    m_cnt = 16'h0;
    m_fill = 8'h0;
    m_ovr = 1'b0;
    tick();
    rst = 1'b0;
    cpu_rd(OFS_CMD, 1'b1, g);

    // Randomized traffic against the model.
    for (int it = 0; it < 250 && cyc < NC - 400; it++) begin
      r = int'($urandom_range(0, 10));
      case (r)
        0: cpu_wr(OFS_PTR_LO, 8'($urandom));
        1: cpu_wr(OFS_PTR_HI, 8'($urandom));
        2: cpu_wr(OFS_STRIDE, 8'($urandom_range(0, 5)));
        3, 4: cpu_wr(OFS_DATA, 8'($urandom));
        5: cpu_rd(OFS_DATA, 1'b1, g);
        6: begin
          cpu_wr(OFS_FILLVAL, 8'($urandom));
          cpu_wr(OFS_CNT_LO, 8'($urandom_range(0, 12)));
          cpu_wr(OFS_CNT_HI, 8'h00);
          cpu_wr(OFS_CMD, 8'h01);
        end
        7: cpu_rd(OFS_CMD, 1'b1, g);
        8: cpu_wr(OFS_CMD, 8'($urandom_range(0, 3)));
        9: cpu_rd(3'($urandom), 1'b0, g);
        default: wait_idle();
      endcase
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
